// File: rtl/wm_panel_ctrl.sv
// Washing-machine front panel: conditions the start/pause/cancel buttons and runs the
// run/pause/cancel state machine, including the end-of-cycle beep sequence.
module wm_panel_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned BEEP_CYCLES     = 8,
    parameter int unsigned BEEP_COUNT      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_raw,
    input  logic       pause_raw,
    input  logic       cancel_raw,
    input  logic       cycle_done,
    output logic       start_button,
    output logic       pause_button,
    output logic       beep,
    output logic [1:0] panel_state
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PH_W  = $clog2(BEEP_CYCLES + 1);
    localparam int unsigned NUM_W = $clog2(BEEP_COUNT + 1);

    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(BEEP_CYCLES - 1);
    localparam logic [NUM_W-1:0] NUM_LAST = NUM_W'(BEEP_COUNT - 1);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StRun    = 2'b01,
        StPaused = 2'b10,
        StFinish = 2'b11
    } state_e;

    logic [2:0] raw;
    logic [2:0] evt;
    logic       start_evt;
    logic       pause_evt;
    logic       cancel_evt;

    assign raw        = {cancel_raw, pause_raw, start_raw};
    assign start_evt  = evt[0];
    assign pause_evt  = evt[1];
    assign cancel_evt = evt[2];

    // Per-button sync, debounce and press-edge detection.
    for (genvar i = 0; i < 3; i++) begin : g_btn
        logic            sync1;
        logic            sync2;
        logic            level;
        logic            level_prev;
        logic [DB_W-1:0] cnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                sync1      <= 1'b0;
                sync2      <= 1'b0;
                level      <= 1'b0;
                level_prev <= 1'b0;
                cnt        <= '0;
            end else begin
                sync1      <= raw[i];
                sync2      <= sync1;
                level_prev <= level;
                if (sync2 == level) begin
                    cnt <= '0;
                end else if (cnt == DB_MAX) begin
                    // Disagreement has persisted DEBOUNCE_CYCLES samples: accept it.
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign evt[i] = level & ~level_prev;
    end

    state_e           state;
    logic [PH_W-1:0]  phase_cnt;
    logic [NUM_W-1:0] beep_num;
    logic             beep_hi;

    assign panel_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            start_button <= 1'b0;
            pause_button <= 1'b0;
            beep         <= 1'b0;
            phase_cnt    <= '0;
            beep_num     <= '0;
            beep_hi      <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start_evt) begin
                        state        <= StRun;
                        start_button <= 1'b1;
                        pause_button <= 1'b0;
                    end
                end
                StRun, StPaused: begin
                    if (cancel_evt) begin
                        state        <= StIdle;
                        start_button <= 1'b0;
                        pause_button <= 1'b0;
                    end else if (cycle_done) begin
                        state        <= StFinish;
                        start_button <= 1'b0;
                        pause_button <= 1'b0;
                        beep         <= 1'b1;
                        beep_hi      <= 1'b1;
                        phase_cnt    <= '0;
                        beep_num     <= '0;
                    end else if (state == StRun && pause_evt) begin
                        state        <= StPaused;
                        pause_button <= 1'b1;
                    end else if (state == StPaused && (pause_evt || start_evt)) begin
                        state        <= StRun;
                        pause_button <= 1'b0;
                    end
                end
                StFinish: begin
                    if (cancel_evt) begin
                        state   <= StIdle;
                        beep    <= 1'b0;
                        beep_hi <= 1'b0;
                    end else if (phase_cnt == PH_LAST) begin
                        phase_cnt <= '0;
                        if (beep_hi) begin
                            beep_hi <= 1'b0;
                            beep    <= 1'b0;
                        end else if (beep_num == NUM_LAST) begin
                            state <= StIdle;
                        end else begin
                            beep_num <= beep_num + 1'b1;
                            beep_hi  <= 1'b1;
                            beep     <= 1'b1;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                default: begin
                    state        <= StIdle;
                    start_button <= 1'b0;
                    pause_button <= 1'b0;
                    beep         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wm_panel_ctrl.sv
// Directed bench for wm_panel_ctrl: button conditioning, run/pause/cancel and beep sequence.
module tb_wm_panel_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_raw;
    logic       pause_raw;
    logic       cancel_raw;
    logic       cycle_done;
    logic       start_button;
    logic       pause_button;
    logic       beep;
    logic [1:0] panel_state;

    int n_cmp = 0;
    int n_bad = 0;

    wm_panel_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .BEEP_CYCLES    (8),
        .BEEP_COUNT     (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_raw   (start_raw),
        .pause_raw   (pause_raw),
        .cancel_raw  (cancel_raw),
        .cycle_done  (cycle_done),
        .start_button(start_button),
        .pause_button(pause_button),
        .beep        (beep),
        .panel_state (panel_state)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Packed view {start, pause, beep, state[1:0]}.
    function automatic logic [4:0] outs();
        return {start_button, pause_button, beep, panel_state};
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        start_raw  = 1'b0;
        pause_raw  = 1'b0;
        cancel_raw = 1'b0;
        cycle_done = 1'b0;

        // 1: reset held three cycles
        step(1); check("reset_c1", outs(), 5'b000_00);
        step(1); check("reset_c2", outs(), 5'b000_00);
        step(1); check("reset_c3", outs(), 5'b000_00);
        reset = 1'b0;

        // 2: start press, latency DEBOUNCE+3 edges
        start_raw = 1'b1;
        step(6); check("start_lat_n5", outs(), 5'b000_00);
        step(1); check("start_lat_n6", outs(), 5'b000_00);
        step(1); check("start_lat_n7", outs(), 5'b100_01);
        step(50); check("start_held", outs(), 5'b100_01);
        start_raw = 1'b0;
        step(10); check("start_release", outs(), 5'b100_01);

        // 3: pause glitch, then real pause presses
        pause_raw = 1'b1;
        step(3);
        pause_raw = 1'b0;
        step(10); check("pause_glitch", outs(), 5'b100_01);
        pause_raw = 1'b1;
        step(7); check("pause_lat_n6", outs(), 5'b100_01);
        step(1); check("pause_lat_n7", outs(), 5'b110_10);
        step(3);
        pause_raw = 1'b0;
        step(10); check("pause_release", outs(), 5'b110_10);
        pause_raw = 1'b1;
        step(8); check("pause_resume", outs(), 5'b100_01);
        pause_raw = 1'b0;
        step(10); check("resume_release", outs(), 5'b100_01);

        // 4: finish and beep sequence, 8 high / 8 low x3
        cycle_done = 1'b1;
        step(1);
        for (int k = 0; k < 48; k++) begin
            logic b;
            b = ((k / 8) % 2) == 0;
            check($sformatf("finish_k%0d", k), outs(), {2'b00, b, 2'b11});
            step(1);
        end
        check("finish_done", outs(), 5'b000_00);
        step(2); check("idle_ignores_done", outs(), 5'b000_00);
        cycle_done = 1'b0;

        // 5: cancel and pause on the same cycle while paused
        start_raw = 1'b1;
        step(8); check("t5_run", outs(), 5'b100_01);
        start_raw = 1'b0;
        step(10);
        pause_raw = 1'b1;
        step(8); check("t5_paused", outs(), 5'b110_10);
        pause_raw = 1'b0;
        step(10);
        pause_raw  = 1'b1;
        cancel_raw = 1'b1;
        step(7); check("t5_pre", outs(), 5'b110_10);
        step(1); check("t5_cancel_wins", outs(), 5'b000_00);
        pause_raw  = 1'b0;
        cancel_raw = 1'b0;
        step(10); check("t5_idle", outs(), 5'b000_00);

        // 6: reset mid-beep with start held through reset
        start_raw = 1'b1;
        step(8); check("t6_run", outs(), 5'b100_01);
        start_raw = 1'b0;
        step(10);
        cycle_done = 1'b1;
        step(1); check("t6_finish", outs(), 5'b001_11);
        cycle_done = 1'b0;
        step(5); check("t6_mid_beep", outs(), 5'b001_11);
        start_raw = 1'b1;
        reset     = 1'b1;
        step(1); check("t6_reset_edge", outs(), 5'b000_00);
        step(2); check("t6_reset_hold", outs(), 5'b000_00);
        reset = 1'b0;
        step(6); check("t6_rel_n5", outs(), 5'b000_00);
        step(1); check("t6_rel_n6", outs(), 5'b000_00);
        step(1); check("t6_rel_n7", outs(), 5'b100_01);
        step(20); check("t6_held", outs(), 5'b100_01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
